// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP datapath units (adder, subtractor, future units).
// Holds field widths, special encodings and the sequential subtractor state enum.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
   localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
   localparam logic [31:0]      POS_INF = 32'h7F80_0000;
   localparam logic [31:0]      NEG_INF = 32'hFF80_0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADDSUB,
      S_NORM,
      S_DONE
   } state_t;

   function automatic logic [31:0] inf_of(input logic sign);
      return sign ? NEG_INF : POS_INF;
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational split of one IEEE-754 single into sign, exponent and 24-bit mantissa.
// Subnormals are presented with exponent 1 and a clear hidden bit so alignment needs no special case.
module fp_unpack
   import fp_pkg::*;
(
   input  logic [31:0]      f,
   output logic             sign,
   output logic [EXP_W-1:0] exp,
   output logic [MAN_W:0]   man,
   output logic             is_max
);

   logic exp_zero;

   assign exp_zero = (f[30:23] == '0);
   assign sign     = f[31];
   assign exp      = exp_zero ? 8'd1 : f[30:23];
   assign man      = {~exp_zero, f[22:0]};
   assign is_max   = (f[30:23] == EXP_MAX);

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle single-precision subtractor (result = a - b) with truncating rounding.
// Alignment and normalisation proceed one bit per cycle behind a start/done handshake.
module fp_sub_seq
   import fp_pkg::*;
#(
   parameter int SHIFT_CLAMP = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);

   // Handshake: start is sampled only while idle (busy=0); operands are captured on that edge.
   // done pulses for exactly one cycle with result valid, and result holds until the next accept.

   state_t             state, state_n;
   logic               sx, sx_n;
   logic               sub, sub_n;
   logic               special, special_n;
   logic [EXP_W-1:0]   ex, ex_n;
   logic [EXP_W-1:0]   diff, diff_n;
   logic [MAN_W+1:0]   mx, mx_n;
   logic [MAN_W:0]     my, my_n;
   logic [31:0]        spec_res, spec_res_n;
   logic [31:0]        result_n;
   logic [EXP_W-1:0]   d_raw;
   logic [EXP_W-1:0]   e_inc;

   logic               sa, sb_raw, sb_eff, a_max, b_max, a_ge;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W:0]     ma, mb;

   fp_unpack u_unpack_a (.f(a), .sign(sa),     .exp(ea), .man(ma), .is_max(a_max));
   fp_unpack u_unpack_b (.f(b), .sign(sb_raw), .exp(eb), .man(mb), .is_max(b_max));

   assign sb_eff = ~sb_raw;
   assign a_ge   = ({ea, ma} >= {eb, mb});

   always_comb begin
      state_n    = state;
      sx_n       = sx;
      sub_n      = sub;
      special_n  = special;
      ex_n       = ex;
      diff_n     = diff;
      mx_n       = mx;
      my_n       = my;
      spec_res_n = spec_res;
      result_n   = result;
      d_raw      = '0;
      e_inc      = ex + 8'd1;
      done       = 1'b0;
      busy       = (state != S_IDLE);

      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_ALIGN;
               if (a_ge) begin
                  sx_n  = sa;
                  ex_n  = ea;
                  mx_n  = {1'b0, ma};
                  my_n  = mb;
                  d_raw = ea - eb;
               end else begin
                  sx_n  = sb_eff;
                  ex_n  = eb;
                  mx_n  = {1'b0, mb};
                  my_n  = ma;
                  d_raw = eb - ea;
               end
               // Beyond the clamp the smaller operand cannot affect a truncated result.
               if (d_raw >= 8'(SHIFT_CLAMP)) begin
                  my_n   = '0;
                  diff_n = '0;
               end else begin
                  diff_n = d_raw;
               end
               sub_n      = sa ^ sb_eff;
               special_n  = a_max | b_max;
               spec_res_n = (a_max && b_max && (sa != sb_eff)) ? QNAN
                                                               : inf_of(a_max ? sa : sb_eff);
            end
         end

         S_ALIGN: begin
            if (special) begin
               result_n = spec_res;
               state_n  = S_DONE;
            end else if (diff != '0) begin
               my_n   = my >> 1;
               diff_n = diff - 8'd1;
            end else begin
               state_n = S_ADDSUB;
            end
         end

         S_ADDSUB: begin
            // X has the larger magnitude, so the difference never goes negative.
            mx_n    = sub ? ({1'b0, mx[MAN_W:0]} - {1'b0, my})
                          : ({1'b0, mx[MAN_W:0]} + {1'b0, my});
            state_n = S_NORM;
         end

         S_NORM: begin
            if (mx[MAN_W+1]) begin
               result_n = (e_inc == EXP_MAX) ? {sx, EXP_MAX, 23'b0}
                                             : {sx, e_inc, mx[MAN_W:1]};
               state_n  = S_DONE;
            end else if (mx == '0) begin
               result_n = 32'h0;
               state_n  = S_DONE;
            end else if (mx[MAN_W] || ex == 8'd1) begin
               result_n = {sx, (mx[MAN_W] ? ex : 8'd0), mx[MAN_W-1:0]};
               state_n  = S_DONE;
            end else begin
               mx_n = {mx[MAN_W:0], 1'b0};
               ex_n = ex - 8'd1;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end

         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         sx       <= 1'b0;
         sub      <= 1'b0;
         special  <= 1'b0;
         ex       <= '0;
         diff     <= '0;
         mx       <= '0;
         my       <= '0;
         spec_res <= '0;
         result   <= '0;
      end else begin
         state    <= state_n;
         sx       <= sx_n;
         sub      <= sub_n;
         special  <= special_n;
         ex       <= ex_n;
         diff     <= diff_n;
         mx       <= mx_n;
         my       <= my_n;
         spec_res <= spec_res_n;
         result   <= result_n;
      end
   end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq: hand-computed differences, done-cycle latency and reset abort.
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        done;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fp_sub_seq #(.SHIFT_CLAMP(26)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Start in cycle 0, optionally re-pulse start in cycle extra_cyc, watch 60 cycles.
   task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] er, input int ecyc, input int extra_cyc);
      int          done_cyc = -1;
      int          pulses   = 0;
      logic [31:0] res_at_done = 'x;
      @(negedge clk);
      a     = va;
      b     = vb;
      start = 1'b1;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = (c == extra_cyc);
         if (c == 1) chk({tag, " busy_c1"}, 32'(busy), 32'd1);
         if (done) begin
            pulses++;
            if (done_cyc < 0) begin
               done_cyc    = c;
               res_at_done = result;
            end
         end
      end
      chk({tag, " done_cycle"}, 32'(done_cyc), 32'(ecyc));
      chk({tag, " pulses"}, 32'(pulses), 32'd1);
      chk({tag, " result"}, res_at_done, er);
      chk({tag, " held"}, result, er);
      chk({tag, " idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int pulses;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      #1;
      chk("reset result", result, 32'h0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      run_op("3-1",        32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5,  0);
      run_op("1-1",        32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4,  0);
      run_op("1-0.75",     32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 7,  0);
      run_op("1-(-1)",     32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4,  0);
      run_op("inf-inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2,  1);
      run_op("1-(-inf)",   32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000, 2,  0);
      run_op("1-3",        32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 5,  0);
      run_op("subnormal",  32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 4,  0);
      run_op("d25",        32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 29, 0);
      run_op("d26 clamp",  32'h4C80_0000, 32'h3F80_0000, 32'h4C80_0000, 4,  0);
      run_op("overflow",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4,  0);

      // Reset in cycle 5 of a 23-shift alignment must abort without a done pulse.
      @(negedge clk);
      a     = 32'h4B00_0000;
      b     = 32'h3F80_0000;
      start = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) pulses++;
      end
      chk("pre-reset busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort result", result, 32'h0);
      chk("abort done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("abort no done", 32'(pulses), 32'd0);
      run_op("3-1 after rst", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 5, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
